// File: rtl/cache_bus_arbiter.sv
// Common-bus arbiter for the MESI cache system.
// One processor-side transaction owns the bus at a time. Within that
// transaction, at most one data supplier (a snooping cache or memory)
// is granted Data_Bus_Com. Every output comes straight from a flop.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no owner; all grants low; arbitrate pending proc requests
// PROC_OWN | one core owns the bus; no data supplier granted
// DATA_OWN | owner plus exactly one supplier (snoop cache or memory)
module cache_bus_arbiter #(
  parameter int NUM_PROC  = 8,
  parameter int NUM_SNOOP = 4,
  localparam int PW = $clog2(NUM_PROC),
  localparam int SW = $clog2(NUM_SNOOP)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
  input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
  input  logic                 Mem_snoop_req,
  output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
  output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop_vec,
  output logic                 Com_Bus_Gnt_snoop,
  output logic                 Mem_snoop_gnt,
  output logic [PW-1:0]        Bus_owner,
  output logic                 Bus_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PROC_OWN = 2'd1,
    DATA_OWN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PROC-1:0]  gnt_proc_q, gnt_proc_d;
  logic [NUM_SNOOP-1:0] gnt_snoop_q, gnt_snoop_d;
  logic                 snoop_any_q, snoop_any_d;
  logic                 mem_gnt_q, mem_gnt_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic [PW-1:0]        proc_ptr_q, proc_ptr_d;
  logic [SW-1:0]        snoop_ptr_q, snoop_ptr_d;

  logic [PW-1:0]        proc_win;
  logic [SW-1:0]        snoop_win;
  logic                 owner_req;
  logic                 supplier_req;

  // Round-robin pick: first requester strictly after ptr, wrapping.
  function automatic logic [PW-1:0] pick_proc(input logic [NUM_PROC-1:0] req,
                                              input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    logic          found;
    int            t;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_PROC; i++) begin
      t = int'(ptr) + i;
      if (t >= NUM_PROC) t = t - NUM_PROC;
      if (!found && req[PW'(t)]) begin
        pick  = PW'(t);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [SW-1:0] pick_snoop(input logic [NUM_SNOOP-1:0] req,
                                               input logic [SW-1:0] ptr);
    logic [SW-1:0] pick;
    logic          found;
    int            t;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_SNOOP; i++) begin
      t = int'(ptr) + i;
      if (t >= NUM_SNOOP) t = t - NUM_SNOOP;
      if (!found && req[SW'(t)]) begin
        pick  = SW'(t);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign proc_win     = pick_proc(Com_Bus_Req_proc, proc_ptr_q);
  assign snoop_win    = pick_snoop(Com_Bus_Req_snoop, snoop_ptr_q);
  assign owner_req    = Com_Bus_Req_proc[owner_q];
  // Granted supplier still asking; covers both the snoop and memory case.
  assign supplier_req = (|(gnt_snoop_q & Com_Bus_Req_snoop)) |
                        (mem_gnt_q & Mem_snoop_req);

  // Next-state and next-output decode; losing an owner beats everything.
  always_comb begin
    state_d     = state_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
    mem_gnt_d   = mem_gnt_q;
    owner_d     = owner_q;
    proc_ptr_d  = proc_ptr_q;
    snoop_ptr_d = snoop_ptr_q;

    case (state_q)
      IDLE: begin
        if (|Com_Bus_Req_proc) begin
          gnt_proc_d = '0;
          gnt_proc_d[proc_win] = 1'b1;
          owner_d    = proc_win;
          proc_ptr_d = proc_win;
          state_d    = PROC_OWN;
        end
      end
      PROC_OWN: begin
        if (!owner_req) begin
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          mem_gnt_d   = 1'b0;
          owner_d     = '0;
          state_d     = IDLE;
        end else if (|Com_Bus_Req_snoop) begin
          gnt_snoop_d = '0;
          gnt_snoop_d[snoop_win] = 1'b1;
          snoop_ptr_d = snoop_win;
          state_d     = DATA_OWN;
        end else if (Mem_snoop_req) begin
          mem_gnt_d = 1'b1;
          state_d   = DATA_OWN;
        end
      end
      DATA_OWN: begin
        if (!owner_req) begin
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          mem_gnt_d   = 1'b0;
          owner_d     = '0;
          state_d     = IDLE;
        end else if (!supplier_req) begin
          gnt_snoop_d = '0;
          mem_gnt_d   = 1'b0;
          state_d     = PROC_OWN;
        end
      end
      default: begin
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        mem_gnt_d   = 1'b0;
        owner_d     = '0;
        state_d     = IDLE;
      end
    endcase

    busy_d      = |gnt_proc_d;
    snoop_any_d = |gnt_snoop_d;
  end

  // State and output registers; pointers reset to last index so 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      snoop_any_q <= 1'b0;
      mem_gnt_q   <= 1'b0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      proc_ptr_q  <= PW'(NUM_PROC - 1);
      snoop_ptr_q <= SW'(NUM_SNOOP - 1);
    end else begin
      state_q     <= state_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
      snoop_any_q <= snoop_any_d;
      mem_gnt_q   <= mem_gnt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      proc_ptr_q  <= proc_ptr_d;
      snoop_ptr_q <= snoop_ptr_d;
    end
  end

  assign Com_Bus_Gnt_proc      = gnt_proc_q;
  assign Com_Bus_Gnt_snoop_vec = gnt_snoop_q;
  assign Com_Bus_Gnt_snoop     = snoop_any_q;
  assign Mem_snoop_gnt         = mem_gnt_q;
  assign Bus_owner             = owner_q;
  assign Bus_busy              = busy_q;

endmodule
